// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU arbitration controller.
//   state_t    : controller FSM states
//   alu_req_t  : payload of one ALU request as seen at the arbiter output
//   ALU_*      : ALU mode encodings (the controller passes them through untouched)
//   FLAG_*     : bit positions inside a {z,c,s,o} flag nibble
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] mode;
        logic [7:0] op1;
        logic [7:0] op2;
        logic       wflags;
    } alu_req_t;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_PASS1 = 4'h2;
    localparam logic [3:0] ALU_PASS2 = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_OR    = 4'h5;
    localparam logic [3:0] ALU_XOR   = 4'h6;
    localparam logic [3:0] ALU_RSUB  = 4'h7;
    localparam logic [3:0] ALU_INC   = 4'h8;
    localparam logic [3:0] ALU_DEC   = 4'h9;
    localparam logic [3:0] ALU_ROL   = 4'hA;
    localparam logic [3:0] ALU_ROR   = 4'hB;
    localparam logic [3:0] ALU_SHL   = 4'hC;
    localparam logic [3:0] ALU_SHR   = 4'hD;
    localparam logic [3:0] ALU_SAR   = 4'hE;
    localparam logic [3:0] ALU_NEG   = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   req        : request bits, bit i = requester i
//   last_grant : index of the requester granted most recently
//   enable     : when low no grant is issued
//   grant      : one-hot grant (or zero)
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // contention: the requester that did not win last time goes
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one combinational ALU between the execute stage (requester 0) and
// the interrupt/auxiliary path (requester 1). One op runs at a time:
// IDLE (arbitrate/accept) -> EXEC (ALU enabled one cycle) -> RESP (hold result).
//   clk, reset           : clock, async active-high reset
//   req_valid/req_ready  : per-requester request handshake
//   req{0,1}_*           : per-requester mode/operands/flag-commit
//   rsp_*                : response channel (valid/ready, id, result, flags)
//   flags_q              : architectural flag register {z,c,s,o}
//   alu_*                : drive/sample of the external ALU
module alu_arbiter_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter logic       PRIO_INIT = 1'b0,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req0_mode,
    input  logic [7:0] req0_op1,
    input  logic [7:0] req0_op2,
    input  logic       req0_wflags,
    input  logic [3:0] req1_mode,
    input  logic [7:0] req1_op1,
    input  logic [7:0] req1_op2,
    input  logic       req1_wflags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_flags,
    output logic [3:0] flags_q,
    output logic       alu_enable,
    output logic [3:0] alu_mode,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic [3:0] alu_current_flags,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags
);

    state_t     state;
    logic       last_grant;
    logic       lat_wflags;
    logic       lat_id;
    logic [1:0] grant;
    alu_req_t   sel_req;

    rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .grant      (grant)
    );

    // grant is only nonzero in IDLE, so req_ready is already qualified
    assign req_ready         = grant;
    assign alu_current_flags = flags_q;

    always_comb begin
        sel_req = '{mode: req0_mode, op1: req0_op1, op2: req0_op2, wflags: req0_wflags};
        if (grant[1])
            sel_req = '{mode: req1_mode, op1: req1_op1, op2: req1_op2, wflags: req1_wflags};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ~PRIO_INIT;
            lat_wflags <= 1'b0;
            lat_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_flags  <= 4'h0;
            flags_q    <= FLAGS_RST;
            alu_enable <= 1'b0;
            alu_mode   <= 4'h0;
            alu_op1    <= 8'h00;
            alu_op2    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        alu_mode   <= sel_req.mode;
                        alu_op1    <= sel_req.op1;
                        alu_op2    <= sel_req.op2;
                        lat_wflags <= sel_req.wflags;
                        lat_id     <= grant[1];
                        last_grant <= grant[1];
                        alu_enable <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for the whole cycle; sample now
                    rsp_data   <= alu_out;
                    rsp_flags  <= alu_flags;
                    rsp_id     <= lat_id;
                    if (lat_wflags)
                        flags_q <= alu_flags;
                    alu_enable <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
module tb_alu_arbiter_ctrl;
    import alu_ctrl_pkg::*;

    localparam logic [3:0] FRST = 4'b1010;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid, req_ready;
    logic [3:0] req0_mode, req1_mode;
    logic [7:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic       req0_wflags, req1_wflags;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags, flags_q;
    logic       alu_enable;
    logic [3:0] alu_mode, alu_current_flags, alu_flags;
    logic [7:0] alu_op1, alu_op2, alu_out;

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(.PRIO_INIT(1'b0), .FLAGS_RST(FRST)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_mode(req0_mode), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_wflags(req0_wflags),
        .req1_mode(req1_mode), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_wflags(req1_wflags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .flags_q(flags_q),
        .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_current_flags(alu_current_flags), .alu_out(alu_out), .alu_flags(alu_flags)
    );

    // reference ALU: returns {result[7:0], z, c, s, o}
    function automatic logic [11:0] alu_ref(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       cy, ov;
        s = 9'd0; r = 8'd0; cy = 1'b0; ov = 1'b0;
        case (m)
            ALU_ADD:   begin s = {1'b0, a} + {1'b0, b};         r = s[7:0]; cy = s[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
            ALU_SUB:   begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; cy = s[8]; ov = (a[7] != b[7]) && (r[7] != a[7]); end
            ALU_PASS1: r = a;
            ALU_PASS2: r = b;
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_RSUB:  begin s = {1'b0, b} + {1'b0, ~a} + 9'd1; r = s[7:0]; cy = s[8]; ov = (a[7] != b[7]) && (r[7] != b[7]); end
            ALU_INC:   begin s = {1'b0, a} + 9'd1;              r = s[7:0]; cy = s[8]; ov = (a == 8'h7F); end
            ALU_DEC:   begin s = {1'b0, a} + 9'h0FF;            r = s[7:0]; cy = s[8]; ov = (a == 8'h80); end
            ALU_ROL:   begin r = {a[6:0], a[7]};  cy = a[7]; end
            ALU_ROR:   begin r = {a[0], a[7:1]};  cy = a[0]; end
            ALU_SHL:   begin r = {a[6:0], 1'b0};  cy = a[7]; end
            ALU_SHR:   begin r = {1'b0, a[7:1]};  cy = a[0]; end
            ALU_SAR:   begin r = {a[7], a[7:1]};  cy = a[0]; end
            default:   begin s = {1'b0, ~b} + 9'd1;             r = s[7:0]; cy = s[8]; ov = (b == 8'h80); end
        endcase
        return {r, (r == 8'h00), cy, r[7], ov};
    endfunction

    // external ALU: evaluates while enabled, holds its last value otherwise
    always_latch begin
        if (alu_enable) {alu_out, alu_flags} = alu_ref(alu_mode, alu_op1, alu_op2);
    end

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    logic [3:0] exp_fq;

    always @(negedge clk) if (alu_enable) en_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic [3:0] m, input logic [7:0] a,
                             input logic [7:0] b, input logic w);
        if (id) begin req1_mode = m; req1_op1 = a; req1_op2 = b; req1_wflags = w; end
        else    begin req0_mode = m; req0_op1 = a; req0_op2 = b; req0_wflags = w; end
    endtask

    // wait (bounded) at negedges for req_ready != 0
    task automatic wait_grant(output int n);
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 10) begin @(negedge clk); n++; end
    endtask

    // one full op from a single requester, with latency and result checks
    task automatic run_op(input string nm, input logic id, input logic [3:0] m, input logic [7:0] a,
                          input logic [7:0] b, input logic w, input logic [7:0] ed,
                          input logic [3:0] ef, input logic [3:0] efq);
        int n, e0;
        @(posedge clk); #1;
        drive_req(id, m, a, b, w);
        req_valid = id ? 2'b10 : 2'b01;
        wait_grant(n);
        chk({nm, "_grant"}, {30'd0, req_ready}, id ? 32'd2 : 32'd1);
        e0 = en_cnt;
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        chk({nm, "_exec"}, {alu_enable, rsp_valid}, 32'b10);
        @(negedge clk);
        chk({nm, "_rsp"}, {rsp_valid, rsp_id, rsp_data, rsp_flags}, {18'd0, 1'b1, id, ed, ef});
        chk({nm, "_flagsq"}, {alu_current_flags, flags_q}, {24'd0, efq, efq});
        chk({nm, "_en1"}, en_cnt - e0, 32'd1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic       id;
        logic [3:0] mode;
        logic [7:0] a, b;
        logic       w;
        logic [7:0] exp_d;
        logic [3:0] exp_f, exp_fq;
    } vec_t;

    vec_t tv[8];

    initial begin
        int n, e0, na, nr;
        int acc_cyc[4];
        logic acc_id[4];
        logic rid[4];
        logic [11:0] rr;
        logic [3:0] m;
        logic [7:0] a, b;
        logic w, id;

        tv[0] = '{1'b0, ALU_ADD,   8'hF0, 8'h20, 1'b1, 8'h10, 4'b0100, 4'b0100};
        tv[1] = '{1'b1, ALU_NEG,   8'h00, 8'h01, 1'b0, 8'hFF, 4'b0010, 4'b0100};
        tv[2] = '{1'b0, ALU_SUB,   8'h05, 8'h05, 1'b1, 8'h00, 4'b1100, 4'b1100};
        tv[3] = '{1'b1, ALU_AND,   8'hF0, 8'h0F, 1'b1, 8'h00, 4'b1000, 4'b1000};
        tv[4] = '{1'b0, ALU_ADD,   8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011, 4'b0011};
        tv[5] = '{1'b1, ALU_PASS2, 8'h11, 8'h3C, 1'b0, 8'h3C, 4'b0000, 4'b0011};
        tv[6] = '{1'b0, ALU_SHL,   8'h81, 8'h00, 1'b0, 8'h02, 4'b0100, 4'b0011};
        tv[7] = '{1'b1, ALU_XOR,   8'hAA, 8'hAA, 1'b1, 8'h00, 4'b1000, 4'b1000};

        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        drive_req(1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
        drive_req(1'b1, 4'h0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_outs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, flags_q, alu_enable},
            {11'd0, 2'b00, 1'b0, 1'b0, 8'h00, 4'h0, FRST, 1'b0});
        chk("reset_alu", {alu_mode, alu_op1, alu_op2}, 32'd0);
        reset = 1'b0;

        // directed vectors
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), tv[i].id, tv[i].mode, tv[i].a, tv[i].b, tv[i].w,
                   tv[i].exp_d, tv[i].exp_f, tv[i].exp_fq);
        exp_fq = 4'b1000;

        // random ops against the reference ALU
        for (int i = 0; i < 20; i++) begin
            id = 1'($urandom_range(0, 1));
            m  = 4'($urandom_range(0, 15));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            w  = 1'($urandom_range(0, 1));
            rr = alu_ref(m, a, b);
            if (w) exp_fq = rr[3:0];
            run_op($sformatf("rnd%0d", i), id, m, a, b, w, rr[11:4], rr[3:0], exp_fq);
        end

        // stall in RESP: outputs held, no accept even if a request shows up
        run_op("pre_stall", 1'b0, ALU_ADD, 8'hF0, 8'h20, 1'b1, 8'h10, 4'b0100, 4'b0100);
        @(posedge clk); #1;
        drive_req(1'b0, ALU_ADD, 8'h12, 8'h34, 1'b0);
        req_valid = 2'b01;
        wait_grant(n);
        chk("stall_grant", {30'd0, req_ready}, 32'd1);
        e0 = en_cnt;
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("stall_hold%0d", c),
                {rsp_valid, rsp_id, rsp_data, rsp_flags, req_ready, alu_enable, flags_q},
                {12'd0, 1'b1, 1'b0, 8'h46, 4'b0000, 2'b00, 1'b0, 4'b0100});
            if (c == 1) begin drive_req(1'b1, ALU_OR, 8'h01, 8'h02, 1'b1); req_valid = 2'b10; end
            if (c == 3) req_valid = 2'b00;
        end
        chk("stall_en1", en_cnt - e0, 32'd1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("stall_release", {30'd0, rsp_valid, alu_enable}, 32'd0);

        // reset during EXEC of SUB 05-05 with commit
        @(posedge clk); #1;
        drive_req(1'b0, ALU_SUB, 8'h05, 8'h05, 1'b1);
        req_valid = 2'b01;
        wait_grant(n);
        chk("rst_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        chk("rst_in_exec", {31'd0, alu_enable}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async", {rsp_valid, alu_enable, req_ready, flags_q}, {3'b000, 1'b0, FRST});
        e0 = en_cnt;
        @(negedge clk) reset = 1'b0;
        nr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) nr++;
        end
        chk("rst_no_rsp", nr, 32'd0);
        chk("rst_no_exec", en_cnt - e0, 32'd0);
        chk("rst_flagsq", {28'd0, flags_q}, {28'd0, FRST});

        // contention right after reset: grants alternate starting with requester 0
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        drive_req(1'b0, ALU_ADD, 8'h01, 8'h01, 1'b0);
        drive_req(1'b1, ALU_ADD, 8'h02, 8'h02, 1'b0);
        req_valid = 2'b11; rsp_ready = 1'b1;
        na = 0; nr = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (|(req_valid & req_ready) && na < 4) begin
                acc_cyc[na] = c; acc_id[na] = req_ready[1]; na++;
            end
            if (rsp_valid && nr < 4) begin rid[nr] = rsp_id; nr++; end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("cont_accepts", na, 32'd4);
        chk("cont_rsps", nr, 32'd3);
        if (na == 4) begin
            chk("cont_ids", {28'd0, acc_id[0], acc_id[1], acc_id[2], acc_id[3]}, 32'b0101);
            chk("cont_spacing", {acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], acc_cyc[3] - acc_cyc[2]},
                {32'd3, 32'd3, 32'd3});
        end
        if (nr == 3)
            chk("cont_rsp_ids", {29'd0, rid[0], rid[1], rid[2]}, 32'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
Shares the single combinational ArithmeticLogicUnit between two requesters: requester 0 is the instruction execute stage, requester 1 is the interrupt/auxiliary path. The block arbitrates round-robin, registers operands, and drives the ALU for exactly one enabled cycle. It then captures the result and flags, returns them through a valid/ready response channel, and owns the architectural flag register {z,c,s,o}.

Parameters:
PRIO_INIT, 0, requester that wins the first contended grant after reset (0 or 1)
FLAGS_RST, 4'b0000, reset value of the architectural flag register {z,c,s,o}

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  per-requester accept; at most one bit high
req0_mode  in  4  requester 0 ALU mode (0x0..0xF)
req0_op1  in  8  requester 0 operand 1
req0_op2  in  8  requester 0 operand 2
req0_wflags  in  1  requester 0: commit ALU flags to flag register
req1_mode, req1_op1, req1_op2, req1_wflags  in  4/8/8/1  same meanings for requester 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  requester that owns the response
rsp_data  out  8  captured ALU result
rsp_flags  out  4  captured ALU flags {z,c,s,o}
flags_q  out  4  architectural flag register
alu_enable  out  1  ALU enable
alu_mode  out  4  ALU mode
alu_op1  out  8  ALU op1
alu_op2  out  8  ALU op2
alu_current_flags  out  4  driven from flags_q
alu_out  in  8  ALU result
alu_flags  in  4  ALU flags {z,c,s,o}

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, flags_q=FLAGS_RST, alu_enable=0, alu_mode/op1/op2 regs=0, last_grant=~PRIO_INIT.
- IDLE:
  - req_ready is combinational: asserted only in IDLE, one-hot, for the granted requester.
  - With a single valid requester, that requester is granted.
  - With both valid, the grant goes to the requester that is not last_grant.
  - On handshake, latch mode/op1/op2/wflags/id and update last_grant, then go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_enable=1; ALU inputs come from the latched registers.
  - At the clock edge, capture rsp_data<=alu_out and rsp_flags<=alu_flags.
  - If wflags=1, flags_q<=alu_flags.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/data/flags are held stable until rsp_ready.
  - On handshake, go to IDLE. The next grant is earliest on the following cycle.
  - req_ready=0 throughout RESP.
- alu_enable=0 in IDLE and RESP. The ALU holds its last value when disabled; the controller never samples it outside EXEC.
- Latency: request handshake in cycle N, rsp_valid in cycle N+2. Peak throughput is one op per 3 cycles.
- wflags=0: flags_q is untouched, but rsp_flags still reports the ALU flags. This supports compare-without-commit.
- All 16 modes are legal and passed through unmodified. The controller performs no arithmetic.
- Requests are not queued. A requester holds req_valid and its payload until req_ready.
- Mid-operation reset: an in-flight op is discarded, there is no response, and flags_q=FLAGS_RST. Requesters must reissue.
- A request change while req_ready=0 is permitted and has no effect.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state enum {IDLE, EXEC, RESP}
  - mode constants ALU_ADD=0x0, ALU_SUB=0x1, ALU_PASS1=0x2, ALU_PASS2=0x3, ALU_AND=0x4, ALU_OR=0x5, ALU_XOR=0x6, ALU_RSUB=0x7, ALU_INC=0x8, ALU_DEC=0x9, ALU_ROL=0xA, ALU_ROR=0xB, ALU_SHL=0xC, ALU_SHR=0xD, ALU_SAR=0xE, ALU_NEG=0xF
  - flag index constants FLAG_Z=3, FLAG_C=2, FLAG_S=1, FLAG_O=0
- One sub-module: rr_arbiter2. It takes req[1:0], last_grant and enable, and outputs one-hot grant. It is combinational.

Test Plan:
- Reset, then req0 ADD op1=0xF0 op2=0x20 wflags=1 → rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=0x10, rsp_flags=4'b0100, flags_q=4'b0100.
- req1 NEG op2=0x01 wflags=0, with flags_q previously 4'b0100 → rsp_data=0xFF, rsp_flags=4'b0010, flags_q stays 4'b0100.
- Both requesters valid continuously with PRIO_INIT=0, rsp_ready=1 → grants 0,1,0,1; rsp_id alternates; each accept 3 cycles apart.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid/data/flags/id stable, req_ready=2'b00, alu_enable=0, no new accept.
- reset asserted during EXEC of SUB 0x05-0x05 → immediately state IDLE, rsp_valid=0, flags_q=FLAGS_RST; no response after deassert until a new request.
- Single-cycle check: alu_enable high exactly one cycle per accepted request across 20 random ops; compare against a reference ALU model.
